// File: rtl/mii_tx_if.sv
// rtl/mii_tx_if.sv - byte stream handshake feeding the MII transmitter.
// The source drives data/valid/last; the transmitter returns ready.
interface mii_tx_if;
    logic [7:0] s_data;
    logic       s_vld;
    logic       s_last;
    logic       s_rdy;

    modport master (output s_data, output s_vld, output s_last, input s_rdy);
    modport slave  (input s_data, input s_vld, input s_last, output s_rdy);
endinterface

// File: rtl/mii_tx.sv
// rtl/mii_tx.sv - MII nibble transmitter: preamble/SFD, payload, optional pad, CRC-32 FCS, IFG.
// Define MII_TX_PAD_EN to pad short frames with zero bytes up to P_MIN_BYTES before the FCS.
module mii_tx #(
    parameter int P_IFG_NIBBLES = 24,
    parameter int P_MIN_BYTES   = 60
) (
    input  logic       clk,
    input  logic       rst,
    mii_tx_if.slave    src,
    output logic [3:0] tx_data,
    output logic       tx_en,
    output logic       tx_er,
    output logic       busy,
    output logic       underrun
);

    localparam logic [31:0] CRC_POLY = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;
    localparam logic [10:0] CNT_MAX  = 11'h7FF;
    // The IDLE cycle that samples s_vld completes the gap, so IFG itself lasts one cycle less.
    localparam logic [7:0]  IFG_LAST = 8'(P_IFG_NIBBLES - 1);
`ifdef MII_TX_PAD_EN
    localparam logic [10:0] MIN_CNT  = 11'(P_MIN_BYTES);
`endif

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        DATA,
`ifdef MII_TX_PAD_EN
        PAD,
`endif
        FCS,
        IFG
    } state_t;

    state_t      state;
    logic [3:0]  nib_cnt;
    logic        phase;
    logic [7:0]  byte_q;
    logic        last_q;
    logic [10:0] byte_cnt;
    logic [31:0] crc;
    logic [7:0]  ifg_cnt;
    logic [10:0] byte_cnt_inc;

    assign byte_cnt_inc = (byte_cnt == CNT_MAX) ? byte_cnt : byte_cnt + 11'd1;

    function automatic logic [31:0] crc_nib(input logic [31:0] c, input logic [3:0] n);
        logic [31:0] r;
        r = c ^ {28'd0, n};
        for (int k = 0; k < 4; k++) begin
            r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
        end
        return r;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            nib_cnt    <= 4'd0;
            phase      <= 1'b0;
            byte_q     <= 8'd0;
            last_q     <= 1'b0;
            byte_cnt   <= 11'd0;
            crc        <= CRC_INIT;
            ifg_cnt    <= 8'd0;
            tx_data    <= 4'd0;
            tx_en      <= 1'b0;
            tx_er      <= 1'b0;
            busy       <= 1'b0;
            underrun   <= 1'b0;
            src.s_rdy  <= 1'b0;
        end else begin
            tx_er    <= 1'b0;
            underrun <= 1'b0;
            // A ready cycle is always a byte slot: take the byte or flag the underrun.
            if (src.s_rdy) begin
                src.s_rdy <= 1'b0;
                state     <= DATA;
                if (src.s_vld) begin
                    byte_q   <= src.s_data;
                    last_q   <= src.s_last;
                    tx_data  <= src.s_data[3:0];
                    crc      <= crc_nib(crc, src.s_data[3:0]);
                    byte_cnt <= byte_cnt_inc;
                    phase    <= 1'b1;
                end else begin
                    tx_data  <= 4'h0;
                    tx_er    <= 1'b1;
                    underrun <= 1'b1;
                end
            end else begin
                case (state)
                    IDLE: begin
                        byte_cnt <= 11'd0;
                        crc      <= CRC_INIT;
                        if (src.s_vld) begin
                            state   <= PRE;
                            tx_en   <= 1'b1;
                            tx_data <= 4'h5;
                            busy    <= 1'b1;
                            nib_cnt <= 4'd0;
                        end
                    end
                    PRE: begin
                        if (nib_cnt == 4'd14) begin
                            tx_data   <= 4'hD;
                            src.s_rdy <= 1'b1;
                        end else begin
                            tx_data <= 4'h5;
                            nib_cnt <= nib_cnt + 4'd1;
                        end
                    end
                    DATA: begin
                        if (underrun) begin
                            state   <= IFG;
                            tx_en   <= 1'b0;
                            tx_data <= 4'h0;
                            ifg_cnt <= 8'd1;
                        end else if (phase) begin
                            tx_data   <= byte_q[7:4];
                            crc       <= crc_nib(crc, byte_q[7:4]);
                            phase     <= 1'b0;
                            src.s_rdy <= !last_q;
`ifdef MII_TX_PAD_EN
                        end else if (byte_cnt < MIN_CNT) begin
                            state    <= PAD;
                            tx_data  <= 4'h0;
                            crc      <= crc_nib(crc, 4'h0);
                            byte_cnt <= byte_cnt_inc;
                            phase    <= 1'b1;
`endif
                        end else begin
                            state   <= FCS;
                            tx_data <= ~crc[3:0];
                            crc     <= crc >> 4;
                            nib_cnt <= 4'd0;
                        end
                    end
`ifdef MII_TX_PAD_EN
                    PAD: begin
                        if (phase || byte_cnt < MIN_CNT) begin
                            tx_data <= 4'h0;
                            crc     <= crc_nib(crc, 4'h0);
                            phase   <= !phase;
                            if (!phase) byte_cnt <= byte_cnt_inc;
                        end else begin
                            state   <= FCS;
                            tx_data <= ~crc[3:0];
                            crc     <= crc >> 4;
                            nib_cnt <= 4'd0;
                        end
                    end
`endif
                    FCS: begin
                        if (nib_cnt == 4'd7) begin
                            state   <= IFG;
                            tx_en   <= 1'b0;
                            tx_data <= 4'h0;
                            ifg_cnt <= 8'd1;
                        end else begin
                            tx_data <= ~crc[3:0];
                            crc     <= crc >> 4;
                            nib_cnt <= nib_cnt + 4'd1;
                        end
                    end
                    IFG: begin
                        if (ifg_cnt >= IFG_LAST) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            ifg_cnt <= ifg_cnt + 8'd1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        tx_en <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mii_tx.sv
// tb/tb_mii_tx.sv - randomized scoreboard bench for mii_tx against a byte-level frame model.
module tb_mii_tx;

    localparam int IFG  = 24;
    localparam int MINB = 60;

    typedef logic [7:0] bq_t[$];
    typedef struct packed {
        logic [3:0] d;
        logic       er;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] tx_data;
    logic       tx_en;
    logic       tx_er;
    logic       busy;
    logic       underrun;

    mii_tx_if sif();

    mii_tx #(.P_IFG_NIBBLES(IFG), .P_MIN_BYTES(MINB)) dut (
        .clk(clk),
        .rst(rst),
        .src(sif),
        .tx_data(tx_data),
        .tx_en(tx_en),
        .tx_er(tx_er),
        .busy(busy),
        .underrun(underrun)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   prev_en = 1'b0;
    bit   armed = 1'b0;
    int   low_run = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] fcs_of(input bq_t b);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (b[i]) begin
            c = c ^ {24'd0, b[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic push_expected(input bq_t b, input int drop);
        bq_t f;
        logic [31:0] fcs;
        for (int i = 0; i < 15; i++) exp_q.push_back('{d: 4'h5, er: 1'b0});
        exp_q.push_back('{d: 4'hD, er: 1'b0});
        if (drop >= 0) begin
            for (int i = 0; i < drop; i++) begin
                exp_q.push_back('{d: b[i][3:0], er: 1'b0});
                exp_q.push_back('{d: b[i][7:4], er: 1'b0});
            end
            exp_q.push_back('{d: 4'h0, er: 1'b1});
        end else begin
            f = b;
`ifdef MII_TX_PAD_EN
            while (f.size() < MINB) f.push_back(8'h00);
`endif
            foreach (f[i]) begin
                exp_q.push_back('{d: f[i][3:0], er: 1'b0});
                exp_q.push_back('{d: f[i][7:4], er: 1'b0});
            end
            fcs = fcs_of(f);
            for (int k = 0; k < 8; k++) exp_q.push_back('{d: fcs[4*k +: 4], er: 1'b0});
        end
    endtask

    task automatic send_frame(input bq_t b, input int drop, input int rst_at);
        int i = 0;
        int guard = 0;
        logic acc, und;
        push_expected(b, drop);
        while (i < b.size() && guard < 3000) begin
            @(negedge clk);
            guard++;
            sif.s_data = b[i];
            sif.s_last = (i == b.size() - 1);
            sif.s_vld  = (i != drop);
            if (i == rst_at && sif.s_rdy) begin
                rst = 1'b1;
                #1;
                check("rst_tx_en", tx_en, 0);
                check("rst_busy", busy, 0);
                check("rst_s_rdy", sif.s_rdy, 0);
                check("rst_tx_data", tx_data, 0);
                exp_q.delete();
                sif.s_vld = 1'b0;
                repeat (2) @(negedge clk);
                rst = 1'b0;
                return;
            end
            acc = sif.s_rdy && sif.s_vld;
            und = sif.s_rdy && !sif.s_vld;
            if (acc) i++;
            if (und) break;
        end
        check("send_in_time", guard < 3000, 1);
    endtask

    function automatic bq_t rand_bytes(input int n);
        bq_t q;
        for (int i = 0; i < n; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) armed = 1'b0;
            if (tx_en) begin
                if (!prev_en && armed) begin
                    check("ifg_len", low_run, IFG);
                    armed = 1'b0;
                end
                if (exp_q.size() == 0) begin
                    check("unexpected_nibble", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("tx_data", tx_data, e.d);
                    check("tx_er", tx_er, e.er);
                    check("underrun", underrun, e.er);
                end
            end else begin
                if (prev_en && !rst) begin
                    armed   = 1'b1;
                    low_run = 0;
                end
                low_run++;
                check("idle_tx_data", tx_data, 0);
                check("idle_tx_er", tx_er, 0);
                check("idle_underrun", underrun, 0);
                check("idle_s_rdy", sif.s_rdy, 0);
            end
            prev_en = tx_en;
        end
    end

    initial begin
        bq_t f;
        int len, drop, guard;
        sif.s_vld  = 1'b0;
        sif.s_data = 8'd0;
        sif.s_last = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_tx_data", tx_data, 0);
        check("reset_tx_en", tx_en, 0);
        check("reset_tx_er", tx_er, 0);
        check("reset_busy", busy, 0);
        check("reset_underrun", underrun, 0);
        check("reset_s_rdy", sif.s_rdy, 0);
        rst = 1'b0;

        f = {};
        for (int i = 0; i < 9; i++) f.push_back(8'h31 + 8'(i));
        send_frame(f, -1, -1);
        f = {8'hA5};
        send_frame(f, -1, -1);
        send_frame(rand_bytes(64), 5, -1);
        send_frame(rand_bytes(64), -1, -1);
        send_frame(rand_bytes(64), -1, -1);
        for (int n = 0; n < 8; n++) begin
            len  = int'($urandom_range(1, 80));
            drop = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len - 1)) : -1;
            send_frame(rand_bytes(len), drop, -1);
        end
        send_frame(rand_bytes(64), -1, 11);
        send_frame(rand_bytes(20), -1, -1);
        @(posedge clk);
        #1;
        sif.s_vld = 1'b0;

        guard = 0;
        while (exp_q.size() != 0 && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        check("drain", exp_q.size(), 0);
        repeat (IFG + 5) @(negedge clk);
        check("final_busy", busy, 0);
        check("final_tx_en", tx_en, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
